// File: rtl/imem_prog_loader_if.sv
// Byte-stream ingress and instruction-memory write bundle
// for the program loader.
interface imem_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    output reload,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_hold,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    input  reload,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_hold,
    output load_done,
    output load_err
  );
endinterface

// File: rtl/imem_prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into
// instruction memory and holds the core until it verifies.
module imem_prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic reset,
  imem_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        acc_q, acc_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        ready;
  logic        accept;
  logic [15:0] n_hdr;

  assign ready  = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept = bus.in_valid && ready;
  assign n_hdr  = {bus.in_data, cnt_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HDR0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      acc_q   <= acc_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    acc_d   = acc_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          cnt_d[7:0] = bus.in_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          cnt_d[15:8] = bus.in_data;
          if ({1'b0, n_hdr} > DEPTH)
            state_d = S_ERR;
          else if (n_hdr == 16'd0)
            state_d = S_CSUM;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          acc_d  = acc_q ^ bus.in_data;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: wbuf_d[7:0]   = bus.in_data;
            2'd1: wbuf_d[15:8]  = bus.in_data;
            2'd2: wbuf_d[23:16] = bus.in_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {bus.in_data, wbuf_q};
              widx_d  = widx_q + 16'd1;
              if (widx_q == cnt_q - 16'd1)
                state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept)
          state_d = (bus.in_data == acc_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        // Memory port registers keep their last values across reload
        if (bus.reload) begin
          state_d = S_HDR0;
          cnt_d   = '0;
          widx_d  = '0;
          bidx_d  = '0;
          acc_d   = '0;
        end
      end
      default: state_d = S_HDR0;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_hold  = (state_q != S_DONE);
  assign bus.load_done  = (state_q == S_DONE);
  assign bus.load_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for the instruction-memory program loader.
// Writes are logged at the falling edge and checked afterwards.
module tb_imem_prog_loader;

  localparam int AW = 10;

  logic clk;
  logic reset;

  imem_prog_loader_if #(.ADDR_W(AW)) bus ();

  imem_prog_loader #(
    .ADDR_W(AW),
    .IMEM_DEPTH(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int nw;
  logic [AW-1:0] wa [16];
  logic [31:0]   wd [16];

  always @(negedge clk) begin
    if (bus.imem_we && nw < 16) begin
      wa[nw] = bus.imem_addr;
      wd[nw] = bus.imem_wdata;
    end
    if (bus.imem_we) nw = nw + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.reload   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one byte; returns at the negedge before its accepting edge.
  task automatic put(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = bus.in_ready;
      end
    end
    if (!ok) chk("put_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] s [], input bit gaps);
    foreach (s[i]) put(s[i], gaps);
    idle();
  endtask

  task automatic chk_nominal_writes(input int base);
    chk("wa0", 64'(wa[base]), 64'd0);
    chk("wd0", 64'(wd[base]), 64'h00500093);
    chk("wa1", 64'(wa[base+1]), 64'd1);
    chk("wd1", 64'(wd[base+1]), 64'h00a00113);
  endtask

  logic [7:0] nom [];
  logic [7:0] bad [];
  logic [7:0] zero [];
  logic [7:0] rl [];

  initial begin
    n_chk = 0;
    n_fail = 0;
    nw = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.reload = 1'b0;
    nom  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'ha0, 8'h00, 8'h71};
    bad  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'ha0, 8'h00, 8'h70};
    zero = '{8'h00, 8'h00, 8'h00};
    rl   = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h16};

    // Reset state
    do_reset();
    chk("rst_hold", 64'(bus.core_hold), 64'd1);
    chk("rst_done", 64'(bus.load_done), 64'd0);
    chk("rst_err", 64'(bus.load_err), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // Nominal back-to-back load
    nw = 0;
    send(nom, 1'b0);
    chk("nom_done", 64'(bus.load_done), 64'd1);
    chk("nom_hold", 64'(bus.core_hold), 64'd0);
    chk("nom_err", 64'(bus.load_err), 64'd0);
    chk("nom_nw", 64'(nw), 64'd2);
    chk_nominal_writes(0);

    // Bytes offered in DONE must be refused
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hc0 + i);
      chk("done_ready", 64'(bus.in_ready), 64'd0);
    end
    idle();
    chk("done_sticky", 64'(bus.load_done), 64'd1);
    chk("done_nw", 64'(nw), 64'd2);

    // Bad checksum
    do_reset();
    nw = 0;
    send(bad, 1'b0);
    chk("bad_nw", 64'(nw), 64'd2);
    chk_nominal_writes(0);
    chk("bad_err", 64'(bus.load_err), 64'd1);
    chk("bad_hold", 64'(bus.core_hold), 64'd1);
    chk("bad_done", 64'(bus.load_done), 64'd0);
    chk("bad_ready", 64'(bus.in_ready), 64'd0);

    // Oversize header
    do_reset();
    nw = 0;
    put(8'h01, 1'b0);
    put(8'h04, 1'b0);
    idle();
    chk("ovr_err", 64'(bus.load_err), 64'd1);
    chk("ovr_ready", 64'(bus.in_ready), 64'd0);
    chk("ovr_hold", 64'(bus.core_hold), 64'd1);
    repeat (3) @(negedge clk);
    chk("ovr_nw", 64'(nw), 64'd0);

    // Random gaps on in_valid
    do_reset();
    nw = 0;
    send(nom, 1'b1);
    chk("gap_done", 64'(bus.load_done), 64'd1);
    chk("gap_nw", 64'(nw), 64'd2);
    chk_nominal_writes(0);

    // Zero-length image
    do_reset();
    nw = 0;
    send(zero, 1'b0);
    chk("zero_done", 64'(bus.load_done), 64'd1);
    chk("zero_hold", 64'(bus.core_hold), 64'd0);
    chk("zero_nw", 64'(nw), 64'd0);

    // Reset arrives together with the 4th byte of word 1
    do_reset();
    nw = 0;
    for (int i = 0; i < 9; i++) put(nom[i], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rmw_nw", 64'(nw), 64'd1);
    chk("rmw_ready", 64'(bus.in_ready), 64'd1);
    chk("rmw_hold", 64'(bus.core_hold), 64'd1);
    send(nom, 1'b0);
    chk("rmw_nw2", 64'(nw), 64'd3);
    chk_nominal_writes(1);
    chk("rmw_done", 64'(bus.load_done), 64'd1);

    // Reload from DONE
    @(negedge clk);
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    chk("rl_hold", 64'(bus.core_hold), 64'd1);
    chk("rl_done", 64'(bus.load_done), 64'd0);
    chk("rl_ready", 64'(bus.in_ready), 64'd1);
    nw = 0;
    send(rl, 1'b0);
    chk("rl_nw", 64'(nw), 64'd1);
    chk("rl_wa", 64'(wa[0]), 64'd0);
    chk("rl_wd", 64'(wd[0]), 64'h00000513);
    chk("rl_done2", 64'(bus.load_done), 64'd1);
    chk("rl_err", 64'(bus.load_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
